dep_clk_edge_monitor: RTL and testbench
=======================================

# dep_clk_edge_monitor

Receiving end of the DPI-driven dependent-clock scheme: samples a level signal written from C via an exported setter (`other_clk`) in the `clk` domain. It detects both edges, counts them and checks the spacing between them against an expected period. It reports done after a target edge count, or a sticky error, for use as a self-checking monitor in order/DPI regression benches.

## Interface
- `EDGES_TARGET`, default 20: number of edges after which `done` asserts (must be ≥ 1).
- `PERIOD_CYC`, default 1: expected `clk` cycles between consecutive edges.
- `TIMEOUT_CYC`, default 64: maximum cycles without an edge while running (must be > `PERIOD_CYC`).
- `CNT_W`, default 16: width of the edge and gap counters.
- `clk`  in  1  single clock; all state updates on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle pulse that arms the monitor; ignored unless in IDLE.
- `other_clk`  in  1  dependent clock level, written from DPI; treated as data.
- `edge_pulse`  out  1  high for one cycle per detected edge.
- `level`  out  1  last sampled value of `other_clk`.
- `edge_cnt`  out  CNT_W  edges counted since `start`.
- `busy`  out  1  high in RUN.
- `done`  out  1  sticky; EDGES_TARGET edges seen with no error.
- `err`  out  1  sticky error flag.
- `err_code`  out  2  01 = period mismatch, 10 = timeout, 00 = none.
- `err_gap`  out  CNT_W  gap value captured at the error.

## Operation
- States:
  - IDLE: `start` → RUN.
  - RUN: count reaches EDGES_TARGET → DONE; error → ERR.
  - DONE and ERR: hold until `rst`.
- `level` register samples `other_clk` every cycle in every state.
- Edge detection: `edge = other_clk ^ level`. Edges seen in IDLE, DONE or ERR are ignored, so no spurious edge fires at arm time.
- On `start`: `edge_cnt` ← 0, `gap` ← 0, `first` ← 1.
- In RUN:
  - Each cycle without an edge: `gap` increments, saturating at 2^CNT_W−1.
  - On an edge: `edge_cnt` increments and `gap` resets to 1.
  - The first edge after `start` is not period-checked. Every later edge requires `gap == PERIOD_CYC`; otherwise → ERR with code 01 and `err_gap` = gap.
  - With no edge and `gap == TIMEOUT_CYC`: → ERR with code 10.
- Simultaneous events within one cycle:
  - An edge suppresses timeout.
  - A period error on the edge that would reach EDGES_TARGET → ERR, not DONE, and `edge_cnt` still increments.
- `start` while in RUN, DONE or ERR is ignored.
- `edge_cnt` saturates at 2^CNT_W−1; it cannot exceed EDGES_TARGET in practice.

## Timing
- Reset values: `level` 0, `edge_pulse` 0, `edge_cnt` 0, `busy` 0, `done` 0, `err` 0, `err_code` 00, `err_gap` 0; state IDLE.
- A change of `other_clk` sampled at posedge k gives `edge_pulse`=1 and the updated `edge_cnt` in the cycle after posedge k (1-cycle latency). `level` updates at the same edge.
- `done`, `err`, `err_code` and `err_gap` assert in that same cycle as the triggering edge or timeout.
- `busy` rises the cycle after `start` is sampled and falls when DONE or ERR is entered.
- `rst` mid-run: all outputs return to their reset values at the next posedge, and the monitor needs a new `start`.

## Configuration
- `DEP_CLK_MON_PERIOD_CHECK_EN` defined: period-mismatch checking is active as described; code 01 is possible.
- Not defined: edges are counted without any spacing check. The timeout check stays active, and `err_code` can only be 00 or 10.

## Structure
- Package `dep_clk_mon_pkg` holds:
  - the state enum `mon_state_e` (IDLE, RUN, DONE, ERR);
  - the `err_code` localparams `ERR_NONE`, `ERR_PERIOD`, `ERR_TIMEOUT`.
- One sub-module is natural: `dep_clk_edge_det`, containing the `level` register and the edge XOR. The FSM and counters stay in the top.

## Test plan
- Defaults. `start` at cycle 2, then `other_clk` toggled every cycle → `edge_pulse` every cycle, `edge_cnt` counts 1..20, `done`=1 after the 20th edge, `err`=0, `busy`=0 afterwards.
- `PERIOD_CYC`=2, with the 5th gap of 3 cycles → `err`=1, `err_code`=01, `err_gap`=3, `edge_cnt`=5, `done` stays 0.
- `other_clk` frozen after 3 edges, `TIMEOUT_CYC`=8 → `err_code`=10 exactly 8 cycles after the last edge, `edge_cnt`=3.
- `other_clk` toggled before `start` and again after `done` → `edge_pulse` stays 0 and `edge_cnt` is unchanged.
- `rst` pulsed mid-run at `edge_cnt`=7 → all outputs return to reset values next cycle; a new `start` with 20 edges completes with `done`=1.
- Macro undefined, irregular gaps 1–5 cycles with `TIMEOUT_CYC`=8 → `done`=1 after 20 edges, `err`=0.

Source files
------------

// File: rtl/dep_clk_mon_pkg.sv
// rtl/dep_clk_mon_pkg.sv - shared types and constants for the dependent-clock edge monitor
//
// Contents:
//   mon_state_e : monitor FSM state (IDLE, RUN, DONE, ERR)
//   ERR_NONE    : err_code value when no error has been flagged
//   ERR_PERIOD  : err_code value for an edge arriving at the wrong spacing
//   ERR_TIMEOUT : err_code value for too long without any edge

package dep_clk_mon_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } mon_state_e;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_PERIOD  = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

endpackage

// File: rtl/dep_clk_edge_det.sv
// rtl/dep_clk_edge_det.sv - level register and both-edge detector for the dependent clock
//
// Ports:
//   clk       in  1  sampling clock
//   rst       in  1  synchronous active-high reset
//   other_clk in  1  dependent clock level, treated as plain data
//   level     out 1  value of other_clk sampled at the last posedge
//   toggle    out 1  combinational: other_clk differs from level (an edge is pending)

module dep_clk_edge_det
    import dep_clk_mon_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic other_clk,
    output logic level,
    output logic toggle
);

    always_ff @(posedge clk) begin
        if (rst) begin
            level <= 1'b0;
        end else begin
            level <= other_clk;
        end
    end

    // Both rising and falling transitions show up as a difference between
    // the live input and the previous sample.
    assign toggle = other_clk ^ level;

endmodule

// File: rtl/dep_clk_edge_monitor.sv
// rtl/dep_clk_edge_monitor.sv - counts dependent-clock edges and checks their spacing
//
// Optional feature macro: DEP_CLK_MON_PERIOD_CHECK_EN
//   defined     : every edge after the first must be exactly PERIOD_CYC cycles
//                 after the previous one, otherwise ERR with code ERR_PERIOD
//   not defined : edges are only counted; the timeout check remains
//
// Parameters:
//   EDGES_TARGET edges after which done asserts (>= 1)
//   PERIOD_CYC   expected clk cycles between consecutive edges
//   TIMEOUT_CYC  cycles without an edge that trip a timeout (> PERIOD_CYC)
//   CNT_W        width of the edge and gap counters
//
// Ports:
//   clk        in  1      single clock
//   rst        in  1      synchronous active-high reset
//   start      in  1      arm pulse, honoured only in IDLE
//   other_clk  in  1      dependent clock level
//   edge_pulse out 1      one cycle per counted edge
//   level      out 1      last sampled other_clk
//   edge_cnt   out CNT_W  edges counted since start
//   busy       out 1      monitor is in RUN
//   done       out 1      sticky, EDGES_TARGET edges seen without error
//   err        out 1      sticky error flag
//   err_code   out 2      ERR_NONE / ERR_PERIOD / ERR_TIMEOUT
//   err_gap    out CNT_W  gap value captured when the error fired

module dep_clk_edge_monitor
    import dep_clk_mon_pkg::*;
#(
    parameter int EDGES_TARGET = 20,
    parameter int PERIOD_CYC   = 1,
    parameter int TIMEOUT_CYC  = 64,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             other_clk,
    output logic             edge_pulse,
    output logic             level,
    output logic [CNT_W-1:0] edge_cnt,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [1:0]       err_code,
    output logic [CNT_W-1:0] err_gap
);

    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] TARGET_V  = CNT_W'(EDGES_TARGET);
    localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(TIMEOUT_CYC);

    // Parameter sanity: a zero target would never finish and a timeout not
    // longer than the period would fire on healthy traffic.
    if (EDGES_TARGET < 1) begin : g_bad_target
        $error("EDGES_TARGET must be at least 1");
    end
    if (TIMEOUT_CYC <= PERIOD_CYC) begin : g_bad_timeout
        $error("TIMEOUT_CYC must exceed PERIOD_CYC");
    end

    mon_state_e       state, state_next;
    logic [CNT_W-1:0] gap, gap_next;
    logic [CNT_W-1:0] cnt_next, cnt_inc, gap_inc;
    logic             pulse_next, done_next, err_next;
    logic [1:0]       code_next;
    logic [CNT_W-1:0] err_gap_next;
    logic             toggle;
    logic             period_bad;

    dep_clk_edge_det u_edge_det (
        .clk       (clk),
        .rst       (rst),
        .other_clk (other_clk),
        .level     (level),
        .toggle    (toggle)
    );

    assign cnt_inc = (edge_cnt == CNT_MAX) ? edge_cnt : edge_cnt + CNT_ONE;
    assign gap_inc = (gap == CNT_MAX) ? gap : gap + CNT_ONE;

`ifdef DEP_CLK_MON_PERIOD_CHECK_EN
    localparam logic [CNT_W-1:0] PERIOD_V = CNT_W'(PERIOD_CYC);

    // first marks that no edge has been seen since start; that edge has no
    // reference point, so it is exempt from the spacing check.
    logic first, first_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            first <= 1'b0;
        end else begin
            first <= first_next;
        end
    end

    always_comb begin
        first_next = first;
        if (state == IDLE && start) begin
            first_next = 1'b1;
        end else if (state == RUN && toggle) begin
            first_next = 1'b0;
        end
    end

    assign period_bad = !first && (gap != PERIOD_V);
`else
    assign period_bad = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            gap        <= '0;
            edge_cnt   <= '0;
            edge_pulse <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            err_code   <= ERR_NONE;
            err_gap    <= '0;
        end else begin
            state      <= state_next;
            gap        <= gap_next;
            edge_cnt   <= cnt_next;
            edge_pulse <= pulse_next;
            done       <= done_next;
            err        <= err_next;
            err_code   <= code_next;
            err_gap    <= err_gap_next;
        end
    end

    always_comb begin
        state_next   = state;
        gap_next     = gap;
        cnt_next     = edge_cnt;
        pulse_next   = 1'b0;
        done_next    = done;
        err_next     = err;
        code_next    = err_code;
        err_gap_next = err_gap;

        case (state)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                    cnt_next   = '0;
                    gap_next   = '0;
                end
            end
            RUN: begin
                if (toggle) begin
                    // An edge always counts, even when it is the one that
                    // fails the spacing check; it also suppresses timeout.
                    pulse_next = 1'b1;
                    cnt_next   = cnt_inc;
                    gap_next   = CNT_ONE;
                    if (period_bad) begin
                        state_next   = ERR;
                        err_next     = 1'b1;
                        code_next    = ERR_PERIOD;
                        err_gap_next = gap;
                    end else if (cnt_inc >= TARGET_V) begin
                        state_next = DONE;
                        done_next  = 1'b1;
                    end
                end else if (gap == TIMEOUT_V) begin
                    state_next   = ERR;
                    err_next     = 1'b1;
                    code_next    = ERR_TIMEOUT;
                    err_gap_next = gap;
                end else begin
                    gap_next = gap_inc;
                end
            end
            DONE: begin
                state_next = DONE;
            end
            ERR: begin
                state_next = ERR;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy = (state == RUN);

endmodule

// File: tb/tb_dep_clk_edge_monitor.sv
// tb/tb_dep_clk_edge_monitor.sv - self-checking bench for dep_clk_edge_monitor

module tb_dep_clk_edge_monitor;

    localparam int CNT_W = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance with default parameters
    logic             d_rst, d_start, d_oc;
    logic             d_pulse, d_level, d_busy, d_done, d_err;
    logic [CNT_W-1:0] d_cnt, d_err_gap;
    logic [1:0]       d_code;

    dep_clk_edge_monitor u_def (
        .clk        (clk),
        .rst        (d_rst),
        .start      (d_start),
        .other_clk  (d_oc),
        .edge_pulse (d_pulse),
        .level      (d_level),
        .edge_cnt   (d_cnt),
        .busy       (d_busy),
        .done       (d_done),
        .err        (d_err),
        .err_code   (d_code),
        .err_gap    (d_err_gap)
    );

    // Instance with PERIOD_CYC=2, TIMEOUT_CYC=8
    logic             p_rst, p_start, p_oc;
    logic             p_pulse, p_level, p_busy, p_done, p_err;
    logic [CNT_W-1:0] p_cnt, p_err_gap;
    logic [1:0]       p_code;

    dep_clk_edge_monitor #(
        .EDGES_TARGET (20),
        .PERIOD_CYC   (2),
        .TIMEOUT_CYC  (8),
        .CNT_W        (CNT_W)
    ) u_p2 (
        .clk        (clk),
        .rst        (p_rst),
        .start      (p_start),
        .other_clk  (p_oc),
        .edge_pulse (p_pulse),
        .level      (p_level),
        .edge_cnt   (p_cnt),
        .busy       (p_busy),
        .done       (p_done),
        .err        (p_err),
        .err_code   (p_code),
        .err_gap    (p_err_gap)
    );

    typedef struct {
        logic rst;
        logic start;
        logic oc;
        logic exp_pulse;
        int   exp_cnt;
        logic exp_busy;
        logic exp_done;
        logic exp_level;
    } vec_t;

    vec_t vecs[$];
    logic cur_oc;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
        end
    endtask

    task automatic add(input logic r, input logic s, input logic tog,
                       input logic ep, input int cnt, input logic bsy, input logic dn);
        vec_t v;
        cur_oc      = cur_oc ^ tog;
        v.rst       = r;
        v.start     = s;
        v.oc        = cur_oc;
        v.exp_pulse = ep;
        v.exp_cnt   = cnt;
        v.exp_busy  = bsy;
        v.exp_done  = dn;
        v.exp_level = r ? 1'b0 : cur_oc;
        vecs.push_back(v);
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic p_hold();
        step();
    endtask

    task automatic p_tog();
        p_oc = ~p_oc;
        step();
    endtask

    task automatic p_reset_start();
        p_rst = 1'b1; p_start = 1'b0;
        step();
        p_rst = 1'b0; p_start = 1'b1;
        step();
        p_start = 1'b0;
    endtask

    initial begin
        d_rst = 1'b1; d_start = 1'b0; d_oc = 1'b0;
        p_rst = 1'b1; p_start = 1'b0; p_oc = 1'b0;
        cur_oc = 1'b0;

        // ---- vector table for the default instance ----
        add(1, 0, 0, 0, 0, 0, 0);               // reset
        add(0, 0, 1, 0, 0, 0, 0);               // toggles before start ignored
        add(0, 0, 1, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 1, 0);               // start
        for (int k = 1; k <= 20; k++)           // start at k=5 is ignored in RUN
            add(0, (k == 5), 1, 1, k, (k < 20), (k == 20));
        add(0, 0, 1, 0, 20, 0, 1);              // toggles after done ignored
        add(0, 1, 1, 0, 20, 0, 1);              // start after done ignored
        add(0, 0, 0, 0, 20, 0, 1);
        add(1, 0, 0, 0, 0, 0, 0);               // reset clears done
        add(0, 1, 0, 0, 0, 1, 0);
        for (int k = 1; k <= 7; k++)
            add(0, 0, 1, 1, k, 1, 0);
        add(1, 0, 1, 0, 0, 0, 0);               // rst mid-run at edge_cnt=7
        add(0, 0, 0, 0, 0, 0, 0);               // still idle without new start
        add(0, 1, 0, 0, 0, 1, 0);
        for (int k = 1; k <= 20; k++)
            add(0, 0, 1, 1, k, (k < 20), (k == 20));
        add(0, 0, 0, 0, 20, 0, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            d_rst   = vecs[i].rst;
            d_start = vecs[i].start;
            d_oc    = vecs[i].oc;
            step();
            chk($sformatf("v%0d edge_pulse", i), int'(d_pulse), int'(vecs[i].exp_pulse));
            chk($sformatf("v%0d edge_cnt", i),   int'(d_cnt),   vecs[i].exp_cnt);
            chk($sformatf("v%0d busy", i),       int'(d_busy),  int'(vecs[i].exp_busy));
            chk($sformatf("v%0d done", i),       int'(d_done),  int'(vecs[i].exp_done));
            chk($sformatf("v%0d level", i),      int'(d_level), int'(vecs[i].exp_level));
            chk($sformatf("v%0d err", i),        int'(d_err),   0);
            chk($sformatf("v%0d err_code", i),   int'(d_code),  0);
        end

`ifdef DEP_CLK_MON_PERIOD_CHECK_EN
        // ---- period mismatch: gaps of 2, then a gap of 3 on the 5th edge ----
        p_reset_start();
        p_tog();
        for (int k = 0; k < 3; k++) begin
            p_hold();
            p_tog();
        end
        chk("period pre cnt", int'(p_cnt), 4);
        chk("period pre err", int'(p_err), 0);
        p_hold();
        p_hold();
        p_tog();
        chk("period err",      int'(p_err),     1);
        chk("period err_code", int'(p_code),    1);
        chk("period err_gap",  int'(p_err_gap), 3);
        chk("period edge_cnt", int'(p_cnt),     5);
        chk("period done",     int'(p_done),    0);
        chk("period busy",     int'(p_busy),    0);
        p_tog();
        chk("period hold cnt",   int'(p_cnt),   5);
        chk("period hold pulse", int'(p_pulse), 0);
`else
        // ---- irregular gaps without spacing check ----
        begin
            int gaps[20] = '{1, 3, 5, 2, 4, 1, 5, 3, 2, 1, 4, 5, 2, 3, 1, 5, 4, 2, 3, 1};
            p_reset_start();
            for (int e = 0; e < 20; e++) begin
                for (int h = 1; h < gaps[e]; h++) p_hold();
                p_tog();
                chk($sformatf("irreg cnt e%0d", e + 1), int'(p_cnt), e + 1);
            end
            chk("irreg done",     int'(p_done), 1);
            chk("irreg err",      int'(p_err),  0);
            chk("irreg err_code", int'(p_code), 0);
            chk("irreg busy",     int'(p_busy), 0);
        end
`endif

        // ---- timeout: 3 edges then other_clk frozen ----
        p_reset_start();
        chk("timeout reset cnt", int'(p_cnt), 0);
        p_tog();
        p_hold();
        p_tog();
        p_hold();
        p_tog();
        chk("timeout cnt3", int'(p_cnt), 3);
        for (int i = 1; i <= 8; i++) begin
            p_hold();
            if (i < 8) chk($sformatf("timeout early err c%0d", i), int'(p_err), 0);
        end
        chk("timeout err",      int'(p_err),     1);
        chk("timeout err_code", int'(p_code),    2);
        chk("timeout err_gap",  int'(p_err_gap), 8);
        chk("timeout edge_cnt", int'(p_cnt),     3);
        chk("timeout busy",     int'(p_busy),    0);
        chk("timeout done",     int'(p_done),    0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
